// File: rtl/instr_fetch_initiator.sv
// Instruction-fetch bus initiator: sequential word fetch with up to MAX_OUT
// requests in flight, an in-order response FIFO and branch redirect.
module instr_fetch_initiator #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUT   = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        instr_req,
  input  logic        instr_gnt,
  output logic [31:0] instr_addr,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] BOOT = BOOT_ADDR & ~32'h3;

  typedef enum logic {IDLE, REQ} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          stale_q, stale_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  entry_t        mem_q [DEPTH];

  logic          gnt_ok, rv_ok, push, pop, issue, held;
  logic [31:0]   tgt;

  always_comb begin
    held   = (state_q == REQ) && !instr_gnt;
    gnt_ok = (state_q == REQ) && instr_gnt;
    rv_ok  = instr_rvalid && (out_q != '0);
    tgt    = branch_addr & ~32'h3;
    push   = rv_ok && (disc_q == '0) && !branch;
    pop    = (cnt_q != '0) && out_ready && !branch;

    out_d      = out_q + OW'(gnt_ok) - OW'(rv_ok);
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    stale_d    = stale_q;
    rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    rd_d       = pop  ? rd_q + AW'(1) : rd_q;
    wr_d       = push ? wr_q + AW'(1) : wr_q;

    disc_d = disc_q;
    if (rv_ok && (disc_q != '0)) disc_d = disc_q - OW'(1);
    if (gnt_ok && stale_q && (32'(disc_d) < MAX_OUT)) disc_d = disc_d + OW'(1);

    // A request granted after a redirect is stale: skip to the target address.
    if (gnt_ok) begin
      fetch_pc_d = stale_q ? pend_pc_q : fetch_pc_q + 32'd4;
      stale_d    = 1'b0;
    end

    if (branch) begin
      disc_d   = out_d;
      rsp_pc_d = tgt;
      cnt_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
      if (held) begin
        stale_d    = 1'b1;
        pend_pc_d  = tgt;
        fetch_pc_d = fetch_pc_q;
      end else begin
        stale_d    = 1'b0;
        fetch_pc_d = tgt;
      end
    end

    issue   = fetch_en && (32'(out_d) < MAX_OUT) && ((32'(out_d) + 32'(cnt_d)) < DEPTH);
    state_d = (held || issue) ? REQ : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT;
      rsp_pc_q   <= BOOT;
      pend_pc_q  <= BOOT;
      stale_q    <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pend_pc_q  <= pend_pc_d;
      stale_q    <= stale_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (push) mem_q[wr_q] <= '{data: instr_rdata, addr: rsp_pc_q, err: instr_err};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      assert (!(instr_rvalid && (out_q == '0)))
        else $error("instr_rvalid with no outstanding request");
  end

  assign instr_req  = (state_q == REQ);
  assign instr_addr = fetch_pc_q;
  assign out_valid  = (cnt_q != '0);
  assign out_rdata  = mem_q[rd_q].data;
  assign out_addr   = mem_q[rd_q].addr;
  assign out_err    = mem_q[rd_q].err;

endmodule

// File: tb/tb_instr_fetch_initiator.sv
// Directed bench for instr_fetch_initiator with a bus memory that either
// grants/responds with zero wait states or is driven step by step.
module tb_instr_fetch_initiator;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, branch, out_ready;
  logic [31:0] branch_addr;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        out_valid, out_err;
  logic [31:0] out_rdata, out_addr;

  logic        auto, man_gnt, man_rv;
  logic [31:0] err_addr;
  int unsigned n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch_initiator #(.DEPTH(4), .MAX_OUT(2), .BOOT_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .branch(branch),
    .branch_addr(branch_addr), .instr_req(instr_req), .instr_gnt(instr_gnt),
    .instr_addr(instr_addr), .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .instr_err(instr_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_addr(out_addr), .out_err(out_err)
  );

  // Memory: granted addresses queue up; the queue is updated mid-cycle so the
  // head is stable at the sampling edge.
  logic [31:0] q[$];
  logic        rv_pipe, did_pop, did_push, head_v;
  logic [31:0] push_a, head_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_pipe <= 1'b0; did_pop <= 1'b0; did_push <= 1'b0; push_a <= '0;
    end else begin
      rv_pipe  <= auto && instr_req && instr_gnt;
      did_pop  <= instr_rvalid;
      did_push <= instr_req && instr_gnt;
      push_a   <= instr_addr;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      head_v <= 1'b0;
      head_a <= '0;
    end else begin
      if (did_pop && q.size() != 0) void'(q.pop_front());
      if (did_push) q.push_back(push_a);
      head_v <= (q.size() != 0);
      head_a <= (q.size() != 0) ? q[0] : '0;
    end
  end

  assign instr_gnt    = auto ? instr_req : man_gnt;
  assign instr_rvalid = auto ? rv_pipe : man_rv;
  assign instr_rdata  = head_a ^ KEY;
  assign instr_err    = instr_rvalid && head_v && (head_a == err_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_chk(input logic [31:0] a, input logic e);
    int unsigned k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk("pop_valid", 32'(out_valid), 32'd1);
    chk("pop_addr", out_addr, a);
    chk("pop_rdata", out_rdata, a ^ KEY);
    chk("pop_err", 32'(out_err), 32'(e));
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; branch = 1'b0; branch_addr = '0; out_ready = 1'b0;
    auto = 1'b1; man_gnt = 1'b0; man_rv = 1'b0; err_addr = 32'hFFFF_FFFC;
    step(); step();
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("rst_req", 32'(instr_req), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_addr", instr_addr, 32'h0);
      step();
    end

    // Zero-wait streaming
    fetch_en = 1'b1; out_ready = 1'b1;
    step();
    chk("s_req0", 32'(instr_req), 32'd1);
    chk("s_addr0", instr_addr, 32'h0);
    step();
    chk("s_addr1", instr_addr, 32'h4);
    chk("s_valid_early", 32'(out_valid), 32'd0);
    step();
    chk("s_valid", 32'(out_valid), 32'd1);
    chk("s_head0", out_addr, 32'h0);
    step(); chk("s_head1", out_addr, 32'h4);
    step(); chk("s_head2", out_addr, 32'h8);
    step(); chk("s_head3", out_addr, 32'hC);

    // Backpressure fills exactly DEPTH entries
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    repeat (12) step();
    chk("full_req", 32'(instr_req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_head", out_addr, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) pop_chk(32'(4 * i), 1'b0);

    // Error forwarding, then asynchronous reset mid-stream
    do_reset();
    err_addr = 32'h8;
    pop_chk(32'h0, 1'b0);
    pop_chk(32'h4, 1'b0);
    pop_chk(32'h8, 1'b1);
    pop_chk(32'hC, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(instr_req), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr", instr_addr, 32'h0);
    chk("ar_rdata", out_rdata, 32'h0);
    chk("ar_oaddr", out_addr, 32'h0);
    chk("ar_err", 32'(out_err), 32'd0);
    err_addr = 32'hFFFF_FFFC;
    fetch_en = 1'b0;
    step();

    // Grant withheld, then redirect while a request is still ungranted
    auto = 1'b0; man_gnt = 1'b0; man_rv = 1'b0;
    rst_n = 1'b1; fetch_en = 1'b1;
    step();
    chk("hold_req0", 32'(instr_req), 32'd1);
    chk("hold_addr0", instr_addr, 32'h0);
    fetch_en = 1'b0;
    step();
    chk("hold_req1", 32'(instr_req), 32'd1);
    chk("hold_addr1", instr_addr, 32'h0);
    step();
    chk("hold_req2", 32'(instr_req), 32'd1);
    chk("hold_addr2", instr_addr, 32'h0);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    chk("hold_drop", 32'(instr_req), 32'd0);
    man_rv = 1'b1;
    step();
    man_rv = 1'b0;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_oaddr", out_addr, 32'h0);
    step();
    chk("hold_popped", 32'(out_valid), 32'd0);
    fetch_en = 1'b1;
    step();
    chk("ub_req", 32'(instr_req), 32'd1);
    chk("ub_addr", instr_addr, 32'h4);
    branch = 1'b1; branch_addr = 32'h201;
    step();
    branch = 1'b0;
    chk("ub_held_req", 32'(instr_req), 32'd1);
    chk("ub_held_addr", instr_addr, 32'h4);
    man_gnt = 1'b1;
    step();
    chk("ub_tgt_req", 32'(instr_req), 32'd1);
    chk("ub_tgt_addr", instr_addr, 32'h200);
    step();
    man_gnt = 1'b0; fetch_en = 1'b0;
    chk("ub_idle", 32'(instr_req), 32'd0);
    man_rv = 1'b1;
    step();
    chk("ub_stale_drop", 32'(out_valid), 32'd0);
    step();
    man_rv = 1'b0;
    chk("ub_valid", 32'(out_valid), 32'd1);
    chk("ub_oaddr", out_addr, 32'h200);
    step();

    // Redirect with two outstanding and a response in the branch cycle
    out_ready = 1'b0;
    do_reset();
    fetch_en = 1'b1; man_gnt = 1'b1;
    step(); step(); step();
    chk("b2_out2_req", 32'(instr_req), 32'd0);
    man_rv = 1'b1;
    step();
    man_rv = 1'b0;
    chk("b2_valid", 32'(out_valid), 32'd1);
    chk("b2_head", out_addr, 32'h0);
    chk("b2_req8", instr_addr, 32'h8);
    step();
    chk("b2_req_off", 32'(instr_req), 32'd0);
    branch = 1'b1; branch_addr = 32'h103; man_rv = 1'b1; man_gnt = 1'b0; out_ready = 1'b1;
    step();
    branch = 1'b0;
    chk("b2_flushed", 32'(out_valid), 32'd0);
    chk("b2_req", 32'(instr_req), 32'd1);
    chk("b2_addr", instr_addr, 32'h100);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    chk("b2_drop2", 32'(out_valid), 32'd0);
    chk("b2_addr2", instr_addr, 32'h104);
    step();
    man_rv = 1'b0;
    chk("b2_new_valid", 32'(out_valid), 32'd1);
    chk("b2_new_addr", out_addr, 32'h100);
    chk("b2_new_rdata", out_rdata, 32'h100 ^ KEY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
